fetch_seq_ctrl: RTL and testbench

FETCH_SEQ_CTRL -- requirements
Module: fetch_seq_ctrl

---
 rtl/fetch_seq_ctrl_pkg.sv | 20 ++
 rtl/fetch_seq_ctrl_md_busy_timer.sv | 57 +++++
 rtl/fetch_seq_ctrl.sv | 63 ++++++
 tb/tb_fetch_seq_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_seq_ctrl_pkg.sv
// Shared constants and types for the fetch sequencing controller.
package fetch_seq_ctrl_pkg;

   localparam int unsigned MULT_CYCLES = 5;
   localparam int unsigned DIV_CYCLES  = 10;
   localparam logic [31:0] RESET_PC    = 32'h0000_3000;
   localparam int unsigned MD_CNT_W    = 4;

   // Multiply/divide occupancy state.
   typedef enum logic {
      StIdle = 1'b0,
      StBusy = 1'b1
   } md_state_e;

   // Initial down-counter value for an issued operation (0 = mult, 1 = div).
   function automatic logic [MD_CNT_W-1:0] md_load_count(input logic op);
      return op ? MD_CNT_W'(DIV_CYCLES) : MD_CNT_W'(MULT_CYCLES);
   endfunction

endpackage

// File: rtl/fetch_seq_ctrl_md_busy_timer.sv
// Tracks how long the multiply/divide unit stays busy after an issue pulse.
module md_busy_timer
   import fetch_seq_ctrl_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic md_start,
   input  logic md_op,
   output logic md_busy
);

   md_state_e             state_q, state_d;
   logic [MD_CNT_W-1:0]   cnt_q, cnt_d;

   // Next state: load on issue from idle, count down while busy; re-issues while busy are ignored.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         StIdle: begin
            if (md_start) begin
               cnt_d   = md_load_count(md_op);
               state_d = StBusy;
            end
         end
         StBusy: begin
            if (cnt_q == MD_CNT_W'(1)) begin
               cnt_d   = '0;
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q - MD_CNT_W'(1);
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = StIdle;
         end
      endcase
   end

   // State and counter registers; reset aborts any operation in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Busy flag is the registered state itself.
   always_comb begin
      md_busy = (state_q == StBusy);
   end

endmodule

// File: rtl/fetch_seq_ctrl.sv
// Fetch sequencing: PC update, IF/ID enable and ID/EX bubble control, including
// stalls for the hazard unit and for HI/LO consumers while mult/div is busy.
module fetch_seq_ctrl
   import fetch_seq_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc_cur,
   input  logic        redirect,
   input  logic [31:0] redirect_target,
   input  logic        hazard_stall,
   input  logic        md_start,
   input  logic        md_op,
   input  logic        md_use,
   output logic        pc_update,
   output logic [31:0] pc_next,
   output logic        ifid_en,
   output logic        idex_flush,
   output logic        md_busy
);

   logic md_stall;
   logic stall;

   md_busy_timer u_md_busy_timer (
      .clk      (clk),
      .reset    (reset),
      .md_start (md_start),
      .md_op    (md_op),
      .md_busy  (md_busy)
   );

   // Stall sources: hazard unit, or an ID-stage HI/LO user while mult/div is busy or issuing.
   always_comb begin
      md_stall = md_use & (md_busy | md_start);
      stall    = hazard_stall | md_stall;
   end

   // Pipeline enables; reset holds the front end with a bubble in ID/EX.
   always_comb begin
      pc_update  = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
      if (!reset && !stall) begin
         pc_update  = 1'b1;
         ifid_en    = 1'b1;
         idex_flush = 1'b0;
      end
   end

   // Next PC: word-aligned redirect target or sequential; no flush, the delay slot executes.
   // When stalled pc_update is low, so the redirect choice here has no effect.
   always_comb begin
      if (reset) begin
         pc_next = RESET_PC;
      end else if (redirect) begin
         pc_next = redirect_target & 32'hFFFF_FFFC;
      end else begin
         pc_next = pc_cur + 32'd4;
      end
   end

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Directed bench for fetch_seq_ctrl with hand-computed expectations.
module tb_fetch_seq_ctrl;

   logic        clk;
   logic        reset;
   logic [31:0] pc_cur;
   logic        redirect;
   logic [31:0] redirect_target;
   logic        hazard_stall;
   logic        md_start;
   logic        md_op;
   logic        md_use;
   logic        pc_update;
   logic [31:0] pc_next;
   logic        ifid_en;
   logic        idex_flush;
   logic        md_busy;

   int n_cmp = 0;
   int n_err = 0;

   fetch_seq_ctrl dut (
      .clk             (clk),
      .reset           (reset),
      .pc_cur          (pc_cur),
      .redirect        (redirect),
      .redirect_target (redirect_target),
      .hazard_stall    (hazard_stall),
      .md_start        (md_start),
      .md_op           (md_op),
      .md_use          (md_use),
      .pc_update       (pc_update),
      .pc_next         (pc_next),
      .ifid_en         (ifid_en),
      .idex_flush      (idex_flush),
      .md_busy         (md_busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge (start of the next cycle).
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Front-end enables for a given expected stall state.
   task automatic check_enables(input string tag, input logic stalled);
      check({tag, ".pc_update"},  {31'd0, pc_update},  {31'd0, ~stalled});
      check({tag, ".ifid_en"},    {31'd0, ifid_en},    {31'd0, ~stalled});
      check({tag, ".idex_flush"}, {31'd0, idex_flush}, {31'd0, stalled});
   endtask

   initial begin
      reset           = 1'b1;
      pc_cur          = 32'h0000_3000;
      redirect        = 1'b0;
      redirect_target = 32'h0;
      hazard_stall    = 1'b0;
      md_start        = 1'b0;
      md_op           = 1'b0;
      md_use          = 1'b0;

      // Reset held across two edges.
      #1;
      check_enables("rst_comb", 1'b1);
      tick();
      tick();
      check_enables("rst_hold", 1'b1);
      check("rst.md_busy", {31'd0, md_busy}, 32'd0);

      // Free run.
      reset = 1'b0;
      #1;
      check_enables("free", 1'b0);
      check("free.pc_next", pc_next, 32'h0000_3004);

      // Redirect aligns target; sequential wrap at top of address space.
      redirect        = 1'b1;
      redirect_target = 32'h0000_3107;
      #1;
      check("redir.pc_next", pc_next, 32'h0000_3104);
      check_enables("redir", 1'b0);
      redirect = 1'b0;
      pc_cur   = 32'hFFFF_FFFC;
      #1;
      check("wrap.pc_next", pc_next, 32'h0000_0000);
      pc_cur = 32'h0000_3000;

      // Hazard stall overrides redirect.
      hazard_stall = 1'b1;
      redirect     = 1'b1;
      #1;
      check_enables("haz_redir", 1'b1);
      hazard_stall = 1'b0;
      redirect     = 1'b0;
      #1;
      check_enables("haz_clear", 1'b0);

      // Mult with md_use held: stall in cycle 0, busy cycles 1..5, free in cycle 6.
      tick();
      md_start = 1'b1;
      md_op    = 1'b0;
      md_use   = 1'b1;
      #1;
      check_enables("mult.c0", 1'b1);
      check("mult.c0.md_busy", {31'd0, md_busy}, 32'd0);
      tick();
      md_start = 1'b0;
      #1;
      for (int c = 1; c <= 5; c++) begin
         check($sformatf("mult.c%0d.md_busy", c), {31'd0, md_busy}, 32'd1);
         check($sformatf("mult.c%0d.pc_update", c), {31'd0, pc_update}, 32'd0);
         tick();
      end
      check("mult.c6.md_busy", {31'd0, md_busy}, 32'd0);
      check_enables("mult.c6", 1'b0);
      md_use = 1'b0;

      // Div with re-issue at cycle 3: busy exactly cycles 1..10; md_use low so no stall.
      tick();
      md_start = 1'b1;
      md_op    = 1'b1;
      #1;
      check_enables("div.c0", 1'b0);
      tick();
      md_start = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         md_start = (c == 3);
         md_op    = 1'b0;
         #1;
         check($sformatf("div.c%0d.md_busy", c), {31'd0, md_busy}, 32'd1);
         check($sformatf("div.c%0d.pc_update", c), {31'd0, pc_update}, 32'd1);
         tick();
      end
      md_start = 1'b0;
      #1;
      check("div.c11.md_busy", {31'd0, md_busy}, 32'd0);
      tick();
      check("div.c12.md_busy", {31'd0, md_busy}, 32'd0);

      // Reset at cycle 4 of a div, then a fresh mult.
      md_start = 1'b1;
      md_op    = 1'b1;
      #1;
      tick();
      md_start = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         #1;
         check($sformatf("rdiv.c%0d.md_busy", c), {31'd0, md_busy}, 32'd1);
         tick();
      end
      reset    = 1'b1;
      md_start = 1'b1;
      #1;
      check_enables("rdiv.c4", 1'b1);
      check("rdiv.c4.md_busy", {31'd0, md_busy}, 32'd1);
      tick();
      reset    = 1'b0;
      md_start = 1'b1;
      md_op    = 1'b0;
      #1;
      check("rdiv.c5.md_busy", {31'd0, md_busy}, 32'd0);
      tick();
      md_start = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         #1;
         check($sformatf("rmult.c%0d.md_busy", c), {31'd0, md_busy}, 32'd1);
         tick();
      end
      #1;
      check("rmult.c6.md_busy", {31'd0, md_busy}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
